// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and address map for the OAM DMA arbiter and its DMA engine.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } dma_state_t;

    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [15:0] DMA_REG  = 16'hFF46;
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam int unsigned DMA_LEN  = 160;

    localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [7:0]  ECHO_TOP = 8'hDF;
    localparam logic [7:0]  ECHO_OFS = 8'h20;

    // Source pages above 0xDF alias the work-RAM echo region back down by 0x20.
    function automatic logic [7:0] echo_map(input logic [7:0] src);
        return (src <= ECHO_TOP) ? src : (src - ECHO_OFS);
    endfunction

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: START/RD/WR sequencer, byte index and echo-mapped source page.
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic [7:0]  i_src,
    input  logic [7:0]  i_rdata,
    output logic        o_busy,
    output logic        o_rd,
    output logic        o_wr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata
);

    dma_state_t r_state;
    dma_state_t w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] w_idx_nxt;
    logic [7:0] w_src_eff;

    assign w_src_eff = echo_map(i_src);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_rd      = (r_state == ST_RD);
    assign o_wr      = (r_state == ST_WR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 8'h00;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                w_state_nxt = ST_RD;
                w_idx_nxt   = 8'h00;
            end
            ST_RD: begin
                // A stalled RD gives its bus slot to the CPU and retries next cycle.
                if (!i_stall) begin
                    o_mem_req   = 1'b1;
                    o_mem_addr  = {w_src_eff, r_idx};
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = OAM_BASE + {8'h00, r_idx};
                o_mem_wdata = i_rdata;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD;
                    w_idx_nxt   = r_idx + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A register write restarts from any state, including the final WR.
        if (i_start) begin
            w_state_nxt = ST_START;
            w_idx_nxt   = 8'h00;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU / OAM-DMA memory bus arbiter: grant mux, DMA source register and CPU ack path.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy
);

    logic        r_run;
    logic        r_ack;
    logic        r_rd_mem;
    logic [7:0]  r_rdata;
    logic [7:0]  r_dma_src;

    logic        w_req;
    logic        w_is_reg;
    logic        w_is_hram;
    logic        w_grant;
    logic        w_cpu_bus;
    logic        w_stall;
    logic        w_start;
    logic [7:0]  w_rdata_nxt;

    logic        w_dma_busy;
    logic        w_dma_rd;
    logic        w_dma_wr;
    logic        w_dma_req;
    logic        w_dma_we;
    logic [15:0] w_dma_addr;
    logic [7:0]  w_dma_wdata;

    // The ack cycle masks the still-held request so one request yields one access.
    assign w_req     = r_run & cpu_req & ~r_ack;
    assign w_is_reg  = (cpu_addr == DMA_REG);
    assign w_is_hram = is_hram(cpu_addr);
    assign w_start   = w_grant & w_is_reg & cpu_we;

    always_comb begin
        w_grant     = 1'b0;
        w_cpu_bus   = 1'b0;
        w_stall     = 1'b0;
        w_rdata_nxt = 8'h00;
        if (w_req) begin
            if (!w_dma_busy) begin
                w_grant   = 1'b1;
                w_cpu_bus = ~w_is_reg;
            end else if (w_is_reg || w_is_hram) begin
                w_grant   = w_is_reg | ~w_dma_wr;
                w_cpu_bus = w_is_hram & ~w_dma_wr;
                w_stall   = w_grant & w_dma_rd;
            end else begin
                // DMA owns the bus: ordinary accesses complete without touching memory.
                w_grant = 1'b1;
            end
            if (!cpu_we) begin
                w_rdata_nxt = w_is_reg ? r_dma_src : 8'hFF;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= 1'b0;
            r_ack     <= 1'b0;
            r_rd_mem  <= 1'b0;
            r_dma_src <= 8'h00;
        end else begin
            r_run    <= 1'b1;
            r_ack    <= w_grant;
            r_rd_mem <= w_grant & w_cpu_bus & ~cpu_we;
            if (w_start) begin
                r_dma_src <= cpu_wdata;
            end
        end
    end

    // Read data captured at grant, only observed while cpu_ack is high.
    always_ff @(posedge clk) begin
        r_rdata <= w_rdata_nxt;
    end

    oam_dma_engine u_engine (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_stall     (w_stall),
        .i_src       (r_dma_src),
        .i_rdata     (mem_rdata),
        .o_busy      (w_dma_busy),
        .o_rd        (w_dma_rd),
        .o_wr        (w_dma_wr),
        .o_mem_req   (w_dma_req),
        .o_mem_we    (w_dma_we),
        .o_mem_addr  (w_dma_addr),
        .o_mem_wdata (w_dma_wdata)
    );

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        if (w_cpu_bus) begin
            mem_req   = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : 8'h00;
        end else if (w_dma_req) begin
            mem_req   = 1'b1;
            mem_we    = w_dma_we;
            mem_addr  = w_dma_addr;
            mem_wdata = w_dma_wdata;
        end
    end

    assign cpu_ack   = r_ack;
    assign cpu_rdata = !r_ack ? 8'h00 : (r_rd_mem ? mem_rdata : r_rdata);
    assign dma_busy  = w_dma_busy;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a synchronous 64 KiB memory model.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        dma_busy;

    logic [7:0]  mem [0:65535];

    int total = 0;
    int bad = 0;
    int nstrobe = 0;
    int nbusy = 0;
    int nidle_bad = 0;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dma_busy  (dma_busy)
    );

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        if (a == 16'hC123) return 8'h5A;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory model acts on the settled bus, then advance past the edge.
    task automatic step();
        logic [7:0] nxt;
        #1;
        nxt = mem_rdata;
        if (dma_busy === 1'b1) nbusy++;
        if (mem_req === 1'b1) begin
            nstrobe++;
            if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
            else nxt = mem[mem_addr];
        end else if (mem_we !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
            nidle_bad++;
        end
        @(posedge clk);
        mem_rdata = nxt;
        #1;
    endtask

    task automatic cpu_drive(input logic we, input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
    endtask

    task automatic cpu_idle();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_wdata = 8'h00;
    endtask

    task automatic run_idle(input string tag);
        int n;
        n = 0;
        while (dma_busy === 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check(tag, 32'(dma_busy), 32'(0));
    endtask

    task automatic oam_fill(input logic [7:0] v);
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = v;
    endtask

    task automatic check_oam(input string tag, input logic [7:0] src, input int ncopy, input logic [7:0] fill);
        int errs;
        logic [7:0] exp;
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            exp = (i < ncopy) ? src_byte({src, 8'(i)}) : fill;
            if (mem[16'hFE00 + 16'(i)] !== exp) errs++;
        end
        check(tag, 32'(errs), 32'(0));
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[16'(a)] = src_byte(16'(a));
        mem[16'hFF90] = 8'h33;

        // Reset state, with a CPU request already pending
        cpu_drive(1'b0, 16'hC123, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        check("rst_bus", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'(0));
        check("rst_ctl", 32'({dma_busy, cpu_ack, cpu_rdata}), 32'(0));
        rst = 1'b1;
        #1;
        check("rel_gate", 32'(mem_req), 32'(0));

        // Idle CPU read forwarded same cycle, acked next
        step();
        check("idle_rd_strobe", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hC123}));
        check("idle_rd_noack", 32'(cpu_ack), 32'(0));
        step();
        check("idle_rd_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'h5A}));
        check("idle_rd_single", 32'(mem_req), 32'(0));
        cpu_idle();
        step();
        check("ack_pulse", 32'(cpu_ack), 32'(0));

        cpu_drive(1'b1, 16'hC800, 8'h77);
        check("idle_wr_bus", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 16'hC800, 8'h77}));
        step();
        check("idle_wr_ack", 32'(cpu_ack), 32'(1));
        cpu_idle();
        step();
        check("idle_wr_mem", 32'(mem[16'hC800]), 32'(8'h77));

        // Full transfer from 0xC000
        oam_fill(8'h00);
        nbusy = 0;
        nstrobe = 0;
        cpu_drive(1'b1, 16'hFF46, 8'hC0);
        check("reg_no_strobe", 32'(mem_req), 32'(0));
        step();
        check("start", 32'({cpu_ack, dma_busy, mem_req}), 32'({1'b1, 1'b1, 1'b0}));
        cpu_idle();
        step();
        check("rd0", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hC000}));
        step();
        check("wr0", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 16'hFE00, src_byte(16'hC000)}));
        run_idle("c0_done");
        check("c0_busy_cycles", 32'(nbusy), 32'(321));
        check("c0_strobes", 32'(nstrobe), 32'(320));
        check_oam("c0_copy", 8'hC0, 160, 8'h00);

        // HRAM read and non-HRAM read/write during DMA
        oam_fill(8'h00);
        nbusy = 0;
        nstrobe = 0;
        cpu_drive(1'b1, 16'hFF46, 8'hC0);
        step();
        cpu_idle();
        repeat (10) step();
        cpu_drive(1'b0, 16'hFF90, 8'h00);
        check("wr4_kept", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b1, 16'hFE04}));
        step();
        check("hram_grant", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hFF90}));
        step();
        check("hram_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'h33}));
        check("rd5_after_stall", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hC005}));
        cpu_idle();
        step();
        cpu_drive(1'b0, 16'h8000, 8'h00);
        check("blocked_rd_bus", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b1, 16'hFE05}));
        step();
        check("blocked_rd_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'hFF}));
        check("rd6", 32'(mem_addr), 32'(16'hC006));
        cpu_idle();
        step();
        cpu_drive(1'b1, 16'h8001, 8'h99);
        step();
        check("dropped_wr_ack", 32'(cpu_ack), 32'(1));
        cpu_idle();
        run_idle("hram_done");
        check("dropped_wr_mem", 32'(mem[16'h8001]), 32'(src_byte(16'h8001)));
        check("hram_busy_cycles", 32'(nbusy), 32'(322));
        check("hram_strobes", 32'(nstrobe), 32'(321));
        check_oam("hram_copy", 8'hC0, 160, 8'h00);

        // Restart at idx=50 with a new source
        oam_fill(8'h00);
        nbusy = 0;
        cpu_drive(1'b1, 16'hFF46, 8'hC0);
        step();
        cpu_idle();
        repeat (101) step();
        check("rd50", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hC032}));
        cpu_drive(1'b1, 16'hFF46, 8'hD0);
        check("restart_no_strobe", 32'(mem_req), 32'(0));
        step();
        check("restart_start", 32'({dma_busy, mem_req, cpu_ack}), 32'({1'b1, 1'b0, 1'b1}));
        cpu_idle();
        step();
        check("restart_rd0", 32'(mem_addr), 32'(16'hD000));
        run_idle("restart_done");
        check("restart_busy_cycles", 32'(nbusy), 32'(423));
        check_oam("restart_copy", 8'hD0, 160, 8'h00);

        cpu_drive(1'b0, 16'hFF46, 8'h00);
        check("reg_rd_no_strobe", 32'(mem_req), 32'(0));
        step();
        check("reg_rd_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'hD0}));
        cpu_idle();
        step();

        // Register write coinciding with the final WR, echo source page
        oam_fill(8'h00);
        cpu_drive(1'b1, 16'hFF46, 8'hC0);
        step();
        cpu_idle();
        repeat (320) step();
        check("wr159", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b1, 16'hFE9F}));
        cpu_drive(1'b1, 16'hFF46, 8'hE1);
        check("wr159_kept", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b1, 16'hFE9F}));
        step();
        check("final_restart", 32'({dma_busy, mem_req}), 32'({1'b1, 1'b0}));
        cpu_idle();
        step();
        check("echo_rd0", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 16'hC100}));
        run_idle("echo_done");
        check_oam("echo_copy", 8'hC1, 160, 8'h00);

        // Reset at idx=80
        oam_fill(8'hEE);
        cpu_drive(1'b1, 16'hFF46, 8'hC0);
        step();
        cpu_idle();
        repeat (161) step();
        check("rd80", 32'(mem_addr), 32'(16'hC050));
        rst = 1'b0;
        #1;
        check("rst_async_bus", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'(0));
        check("rst_async_ctl", 32'({dma_busy, cpu_ack, cpu_rdata}), 32'(0));
        cpu_drive(1'b0, 16'hC123, 8'h00);
        step();
        step();
        check("rst_hold", 32'(mem_req), 32'(0));
        rst = 1'b1;
        #1;
        check("rel_gate2", 32'(mem_req), 32'(0));
        step();
        check("rel_grant", 32'({mem_req, mem_addr}), 32'({1'b1, 16'hC123}));
        step();
        check("rel_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'h5A}));
        cpu_idle();
        repeat (400) step();
        check("rst_no_dma", 32'(dma_busy), 32'(0));
        check_oam("rst_abandon", 8'hC0, 80, 8'hEE);

        check("idle_bus_clean", 32'(nidle_bad), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock port clk, reset port rst. Reset is asynchronous and active-low.
REQ-002 Port list, one per line (name, direction, width, meaning):
  clk  in  1  system clock, all state on posedge
  rst  in  1  asynchronous active-low reset
  cpu_req  in  1  datapath memory request, held until cpu_ack
  cpu_we  in  1  1=write, 0=read
  cpu_addr  in  16  datapath address
  cpu_wdata  in  8  datapath write data
  cpu_rdata  out  8  read data, valid with cpu_ack
  cpu_ack  out  1  one-cycle completion pulse
  mem_req  out  1  memory bus strobe
  mem_we  out  1  memory write enable
  mem_addr  out  16  memory address
  mem_wdata  out  8  memory write data
  mem_rdata  in  8  synchronous read data, valid the cycle after a read strobe
  dma_busy  out  1  OAM DMA in progress

Function
REQ-003 Memory bus SHALL carry at most one access per cycle; owner is CPU or DMA engine.
REQ-004 DMA idle: a cpu_req not to 0xFF46 SHALL be forwarded to mem_* in the same cycle; cpu_ack SHALL pulse the next cycle, cpu_rdata = mem_rdata for reads.
REQ-005 CPU access to 0xFF46: write SHALL load dma_src[7:0] and start/restart DMA; read SHALL return dma_src; neither SHALL drive mem_req; cpu_ack next cycle.
REQ-006 DMA FSM states: IDLE, START, RD, WR. IDLE->START on 0xFF46 write; START->RD after one cycle, idx=0; RD->WR; WR->RD with idx+1, or WR->IDLE when idx==159.
REQ-007 RD SHALL drive mem_req=1, mem_we=0, mem_addr={src_eff, idx}; WR SHALL drive mem_req=1, mem_we=1, mem_addr=0xFE00+idx, mem_wdata=mem_rdata.
REQ-008 src_eff SHALL equal dma_src when dma_src<=0xDF, else dma_src-0x20 (echo mapping).
REQ-009 Full transfer SHALL be 160 bytes: 1 START + 320 RD/WR cycles absent stalls; dma_busy=1 in START, RD, WR.
REQ-010 While dma_busy, CPU access to HRAM (0xFF80-0xFFFE) or 0xFF46 SHALL win a slot where DMA would enter RD; DMA holds in RD (no strobe) that cycle; WR SHALL never be preempted.
REQ-011 While dma_busy, other CPU reads SHALL ack next cycle with cpu_rdata=0xFF; writes SHALL be dropped and acked; no mem strobe.
REQ-012 0xFF46 write during DMA SHALL abort current transfer: next cycle START, idx=0, new dma_src.
REQ-013 0xFF46 write in same cycle as final WR SHALL take effect: FSM -> START, not IDLE.
REQ-014 mem_* outputs SHALL be 0 when no access granted; cpu_ack never asserted without a preceding grant.

Reset
REQ-015 On rst=0, immediately: state=IDLE, idx=0, dma_src=0x00, dma_busy=0, cpu_ack=0, cpu_rdata=0x00, mem_req=0, mem_we=0, mem_addr=0x0000, mem_wdata=0x00.
REQ-016 Reset mid-DMA SHALL abandon transfer; no further OAM writes after rst deasserts.
REQ-017 Release of rst SHALL be sampled synchronously; first grant no earlier than first posedge after release.

Structure
REQ-018 Shared package SHALL hold dma_state_t enum and constants OAM_BASE=16'hFE00, DMA_REG=16'hFF46, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE, DMA_LEN=160.
REQ-019 One sub-module, oam_dma_engine (FSM, idx counter, src_eff), SHALL be instantiated; grant mux and CPU ack logic live in the top.

Verification
REQ-020 CPU read 0xC123 (mem holds 0x5A), DMA idle -> mem strobe same cycle, cpu_ack next cycle, cpu_rdata=0x5A.
REQ-021 Write 0xC0 to 0xFF46 -> START, then 160 RD/WR pairs, 0xC000..0xC09F copied to 0xFE00..0xFE9F, dma_busy low after 321 cycles.
REQ-022 During DMA, CPU reads 0xFF90 (0x33) and 0x8000 -> 0x33 acked with one-cycle DMA stall; 0x8000 returns 0xFF, no strobe; transfer still complete and correct.
REQ-023 Write 0xE1 to 0xFF46 -> source reads from 0xC100.
REQ-024 Write 0xC0, then 0xD0 to 0xFF46 at idx=50 -> restart; OAM ends holding 0xD000..0xD09F.
REQ-025 Assert rst at idx=80 -> all outputs reset immediately; OAM 0xFE50 onward unchanged.
